// File: rtl/ad_ensm_ctrl.sv
// AD9361 ENSM pin-control sequencer: orders txnrx/enable changes with setup, hold and minimum-on timing.
// Requests arrive from the PS or the TDD logic; enable/txnrx drive up_enable/up_txnrx.
`timescale 1ns/1ps
module ad_ensm_ctrl #(
  parameter int SETUP_CYCLES  = 4,
  parameter int HOLD_CYCLES   = 3,
  parameter int MIN_ON_CYCLES = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [1:0] req_mode,
  input  logic       abort,
  output logic       enable,
  output logic       txnrx,
  output logic [1:0] cur_mode,
  output logic       busy
);

  localparam int MAX_SH = (SETUP_CYCLES > HOLD_CYCLES) ? SETUP_CYCLES : HOLD_CYCLES;
  localparam int MAX_C  = (MAX_SH > MIN_ON_CYCLES) ? MAX_SH : MIN_ON_CYCLES;
  localparam int CW     = $clog2(MAX_C + 1);

  localparam logic [CW-1:0] SETUP_LD = CW'(SETUP_CYCLES - 1);
  localparam logic [CW-1:0] HOLD_LD  = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] ON_MAX   = CW'(MIN_ON_CYCLES);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {IDLE, SETUP, ACTIVE, HOLD} state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [CW-1:0] on_cnt, on_n;
  logic [1:0]    pend, pend_n;
  logic          ready_q;
  logic          en_n, tx_n;
  logic [1:0]    mode_n;
  logic [1:0]    req_eff;
  logic          accept;

  // Ready is registered from the next state; abort only masks it so no request slips in alongside an abort.
  assign req_ready = ready_q & ~abort;
  assign accept    = req_valid & req_ready;
  assign req_eff   = (req_mode == 2'd3) ? 2'd0 : req_mode;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    on_n    = on_cnt;
    pend_n  = pend;
    en_n    = enable;
    tx_n    = txnrx;
    mode_n  = cur_mode;
    case (state)
      IDLE: begin
        if (accept && req_eff != 2'd0) begin
          tx_n    = (req_eff == 2'd2);
          pend_n  = req_eff;
          cnt_n   = SETUP_LD;
          state_n = SETUP;
        end
      end
      SETUP: begin
        if (abort) begin
          pend_n  = '0;
          cnt_n   = HOLD_LD;
          state_n = HOLD;
        end else if (cnt == '0) begin
          en_n    = 1'b1;
          mode_n  = pend;
          on_n    = CNT_ONE;
          state_n = ACTIVE;
        end else begin
          cnt_n = cnt - CNT_ONE;
        end
      end
      ACTIVE: begin
        if (on_cnt != ON_MAX) on_n = on_cnt + CNT_ONE;
        if (abort || (accept && req_eff != cur_mode)) begin
          en_n    = 1'b0;
          mode_n  = '0;
          pend_n  = abort ? 2'd0 : req_eff;
          cnt_n   = HOLD_LD;
          on_n    = '0;
          state_n = HOLD;
        end
      end
      HOLD: begin
        // Abort here only cancels the pending mode; the hold countdown stalls for that cycle.
        if (abort) begin
          pend_n = '0;
        end else if (cnt == '0) begin
          if (pend == 2'd0) begin
            state_n = IDLE;
          end else begin
            tx_n    = (pend == 2'd2);
            cnt_n   = SETUP_LD;
            state_n = SETUP;
          end
        end else begin
          cnt_n = cnt - CNT_ONE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      on_cnt   <= '0;
      pend     <= '0;
      enable   <= 1'b0;
      txnrx    <= 1'b0;
      cur_mode <= '0;
      busy     <= 1'b0;
      ready_q  <= 1'b1;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      on_cnt   <= on_n;
      pend     <= pend_n;
      enable   <= en_n;
      txnrx    <= tx_n;
      cur_mode <= mode_n;
      busy     <= (state_n == SETUP) || (state_n == HOLD);
      ready_q  <= (state_n == IDLE) || (state_n == ACTIVE && on_n == ON_MAX);
    end
  end

endmodule

// File: tb/tb_ad_ensm_ctrl.sv
// Self-checking bench for ad_ensm_ctrl: directed scenarios plus random traffic against a deadline-based model.
`timescale 1ns/1ps
module tb_ad_ensm_ctrl;
  localparam int S = 4;
  localparam int H = 3;
  localparam int M = 8;

  logic       clk = 1'b0;
  logic       rst, req_valid, req_ready, abort, enable, txnrx, busy;
  logic [1:0] req_mode, cur_mode;

  ad_ensm_ctrl #(.SETUP_CYCLES(S), .HOLD_CYCLES(H), .MIN_ON_CYCLES(M)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_mode(req_mode),
    .abort(abort), .enable(enable), .txnrx(txnrx), .cur_mode(cur_mode), .busy(busy)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Model: phase plus absolute edge deadlines rather than down-counters.
  localparam int P_IDLE = 0, P_SET = 1, P_ACT = 2, P_HOLD = 3;
  int         n = 0, ph = P_IDLE, due = 0, t_on = 0, pend = 0;
  bit         m_en = 0, m_tx = 0, cur_abort = 0;
  logic [1:0] m_mode = 0;

  task automatic model_edge(input bit r, input bit v, input logic [1:0] md, input bit a);
    int eff;
    bit rdy, acc;
    n++;
    if (r) begin
      ph = P_IDLE; m_en = 0; m_tx = 0; m_mode = 0; pend = 0;
      return;
    end
    eff = (md == 2'd3) ? 0 : int'(md);
    rdy = !a && (ph == P_IDLE || (ph == P_ACT && n - t_on >= M));
    acc = v && rdy;
    case (ph)
      P_IDLE: if (acc && eff != 0) begin
        m_tx = (eff == 2); pend = eff; ph = P_SET; due = n + S;
      end
      P_SET: if (a) begin
        ph = P_HOLD; pend = 0; due = n + H;
      end else if (n == due) begin
        m_en = 1; m_mode = 2'(pend); t_on = n; ph = P_ACT;
      end
      P_ACT: if (a || (acc && eff != int'(m_mode))) begin
        m_en = 0; m_mode = 0; pend = a ? 0 : eff; ph = P_HOLD; due = n + H;
      end
      default: if (a) begin
        pend = 0; due++;
      end else if (n == due) begin
        if (pend == 0) ph = P_IDLE;
        else begin m_tx = (pend == 2); ph = P_SET; due = n + S; end
      end
    endcase
  endtask

  function automatic logic [5:0] expect_out();
    bit b, r;
    b = (ph == P_SET) || (ph == P_HOLD);
    r = !cur_abort && (ph == P_IDLE || (ph == P_ACT && n + 1 - t_on >= M));
    return {m_en, m_tx, m_mode, b, r};
  endfunction

  task automatic step(input bit r, input bit v, input logic [1:0] md, input bit a);
    @(negedge clk);
    rst = r; req_valid = v; req_mode = md; abort = a; cur_abort = a;
    @(posedge clk);
    model_edge(r, v, md, a);
    #1;
  endtask

  task automatic test_reset;
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    if ({enable, txnrx, cur_mode, busy, req_ready} !== 6'b000001) begin
      miscompares++; $display("FAIL reset_values got=%b exp=%b", {enable, txnrx, cur_mode, busy, req_ready}, 6'b000001);
    end
    vectors++;
  endtask

  task automatic test_rx_start;
    int t_acc, k, bcnt;
    step(0, 1, 2'd1, 0);
    t_acc = n; k = 0; bcnt = busy ? 1 : 0;
    if ({enable, txnrx, cur_mode, busy, req_ready} !== expect_out()) begin
      miscompares++; $display("FAIL rx_accept got=%b exp=%b", {enable, txnrx, cur_mode, busy, req_ready}, expect_out());
    end
    vectors++;
    while (enable !== 1'b1 && k < 20) begin
      step(0, 0, 0, 0); k++;
      if (busy === 1'b1) bcnt++;
      if ({enable, txnrx, cur_mode, busy, req_ready} !== expect_out()) begin
        miscompares++; $display("FAIL rx_setup n=%0d got=%b exp=%b", n, {enable, txnrx, cur_mode, busy, req_ready}, expect_out());
      end
      vectors++;
    end
    if (n - t_acc != S || bcnt != S || cur_mode !== 2'd1 || txnrx !== 1'b0) begin
      miscompares++; $display("FAIL rx_timing delay=%0d busy=%0d mode=%0d tx=%b exp delay=%0d busy=%0d mode=1 tx=0", n - t_acc, bcnt, cur_mode, txnrx, S, S);
    end
    vectors++;
  endtask

  task automatic test_switch_tx;
    int ton, tfall, ttx, k;
    ton = n;
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    if (req_ready !== 1'b0) begin
      miscompares++; $display("FAIL switch_early_ready got=%b exp=0", req_ready);
    end
    vectors++;
    k = 0;
    while (enable === 1'b1 && k < 20) begin
      step(0, 1, 2'd2, 0); k++;
      if ({enable, txnrx, cur_mode, busy, req_ready} !== expect_out()) begin
        miscompares++; $display("FAIL switch_wait n=%0d got=%b exp=%b", n, {enable, txnrx, cur_mode, busy, req_ready}, expect_out());
      end
      vectors++;
    end
    tfall = n; k = 0;
    while (txnrx !== 1'b1 && k < 20) begin
      step(0, 0, 0, 0); k++;
      if ({enable, txnrx, cur_mode, busy, req_ready} !== expect_out()) begin
        miscompares++; $display("FAIL switch_hold n=%0d got=%b exp=%b", n, {enable, txnrx, cur_mode, busy, req_ready}, expect_out());
      end
      vectors++;
    end
    ttx = n; k = 0;
    while (enable !== 1'b1 && k < 20) begin
      step(0, 0, 0, 0); k++;
      if ({enable, txnrx, cur_mode, busy, req_ready} !== expect_out()) begin
        miscompares++; $display("FAIL switch_setup n=%0d got=%b exp=%b", n, {enable, txnrx, cur_mode, busy, req_ready}, expect_out());
      end
      vectors++;
    end
    if (tfall - ton != M || ttx - tfall != H || n - ttx != S || cur_mode !== 2'd2) begin
      miscompares++; $display("FAIL switch_timing on=%0d hold=%0d setup=%0d mode=%0d exp %0d %0d %0d 2", tfall - ton, ttx - tfall, n - ttx, cur_mode, M, H, S);
    end
    vectors++;
  endtask

  task automatic test_same_mode;
    int k = 0;
    while (req_ready !== 1'b1 && k < 20) begin step(0, 0, 0, 0); k++; end
    step(0, 1, 2'd2, 0);
    if ({enable, txnrx, cur_mode, busy} !== 5'b11100 || {enable, txnrx, cur_mode, busy, req_ready} !== expect_out()) begin
      miscompares++; $display("FAIL same_mode got=%b exp=%b", {enable, txnrx, cur_mode, busy, req_ready}, expect_out());
    end
    vectors++;
  endtask

  task automatic test_to_idle;
    int t, k = 0;
    while (req_ready !== 1'b1 && k < 20) begin step(0, 0, 0, 0); k++; end
    step(0, 1, 2'd0, 0);
    t = n; k = 0;
    if (enable !== 1'b0 || busy !== 1'b1) begin
      miscompares++; $display("FAIL idle_fall enable=%b busy=%b exp enable=0 busy=1", enable, busy);
    end
    vectors++;
    while (busy === 1'b1 && k < 20) begin step(0, 0, 0, 0); k++; end
    if (n - t != H || txnrx !== 1'b1 || req_ready !== 1'b1 || {enable, txnrx, cur_mode, busy, req_ready} !== expect_out()) begin
      miscompares++; $display("FAIL idle_return hold=%0d tx=%b rdy=%b exp hold=%0d tx=1 rdy=1", n - t, txnrx, req_ready, H);
    end
    vectors++;
  endtask

  task automatic test_abort_setup;
    int t, k = 0;
    bit saw_en = 0;
    step(0, 1, 2'd2, 0);
    step(0, 0, 0, 0);
    step(0, 1, 2'd1, 1);
    t = n;
    if (req_ready !== 1'b0 || enable !== 1'b0 || busy !== 1'b1) begin
      miscompares++; $display("FAIL abort_cycle rdy=%b en=%b busy=%b exp 0 0 1", req_ready, enable, busy);
    end
    vectors++;
    while (busy === 1'b1 && k < 20) begin
      step(0, 0, 0, 0); k++;
      if (enable === 1'b1) saw_en = 1;
    end
    if (saw_en || n - t != H || cur_mode !== 2'd0 || txnrx !== 1'b1 || {enable, txnrx, cur_mode, busy, req_ready} !== expect_out()) begin
      miscompares++; $display("FAIL abort_hold saw_en=%b hold=%0d mode=%0d tx=%b exp 0 %0d 0 1", saw_en, n - t, cur_mode, txnrx, H);
    end
    vectors++;
  endtask

  task automatic test_reset_mid;
    int k = 0;
    step(0, 1, 2'd2, 0);
    while (enable !== 1'b1 && k < 20) begin step(0, 0, 0, 0); k++; end
    step(1, 1, 2'd2, 0);
    if ({enable, txnrx, cur_mode, busy, req_ready} !== 6'b000001) begin
      miscompares++; $display("FAIL reset_mid got=%b exp=%b", {enable, txnrx, cur_mode, busy, req_ready}, 6'b000001);
    end
    vectors++;
    step(0, 1, 2'd3, 0);
    if ({enable, txnrx, cur_mode, busy, req_ready} !== 6'b000001 || {enable, txnrx, cur_mode, busy, req_ready} !== expect_out()) begin
      miscompares++; $display("FAIL mode3_idle got=%b exp=%b", {enable, txnrx, cur_mode, busy, req_ready}, 6'b000001);
    end
    vectors++;
  endtask

  task automatic test_random;
    bit r, v, a;
    logic [1:0] md;
    for (int i = 0; i < 800; i++) begin
      r  = ($urandom_range(0, 63) == 0);
      v  = 1'($urandom_range(0, 1));
      md = 2'($urandom_range(0, 3));
      a  = ($urandom_range(0, 15) == 0);
      step(r, v, md, a);
      if ({enable, txnrx, cur_mode, busy, req_ready} !== expect_out()) begin
        miscompares++; $display("FAIL random n=%0d got=%b exp=%b", n, {enable, txnrx, cur_mode, busy, req_ready}, expect_out());
      end
      vectors++;
    end
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_mode = 2'd0; abort = 1'b0;
    test_reset();
    test_rx_start();
    test_switch_tx();
    test_same_mode();
    test_to_idle();
    test_abort_setup();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
